// File: rtl/sysray_pkg.sv
// Shared types and sizing helpers for the sysray_n systolic matrix-vector engine.
package sysray_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, LOADED, DRAIN} state_e;

  function automatic int latency(input int rows, input int cols);
    return rows + cols;
  endfunction

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sysray_pe.sv
// Weight-stationary processing element: shift-down weight load, input pass-right,
// psum pass-down with the MAC gated by the input valid.
module sysray_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] w_out,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid_in,
  output logic [DATA_W-1:0] x_out,
  output logic              x_valid_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;

  assign prod     = (2*DATA_W)'($signed(x_in)) * (2*DATA_W)'($signed(w_out));
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_out       <= '0;
      x_out       <= '0;
      x_valid_out <= 1'b0;
      psum_out    <= '0;
    end else begin
      if (w_load) w_out <= w_in;
      x_out       <= x_in;
      x_valid_out <= x_valid_in;
      psum_out    <= x_valid_in ? psum_in + prod_ext : psum_in;
    end
  end

endmodule

// File: rtl/sysray_n.sv
// ROWS x COLS weight-stationary systolic matrix-vector engine: y[c] = sum_r x[r]*W[r][c].
//   state  | meaning
//   IDLE   | no weights resident, waiting for first weight row
//   LOAD   | shifting weight rows in, row count < ROWS
//   LOADED | full matrix resident, input vectors accepted
//   DRAIN  | clear requested, waiting for in-flight vectors to emerge
module sysray_n
  import sysray_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLS*DATA_W-1:0] weight_i,
  input  logic                   weight_valid_i,
  output logic                   weight_ready_o,
  input  logic                   weights_clear_i,
  output logic                   weights_loaded_o,
  input  logic [ROWS*DATA_W-1:0] data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic [COLS*ACC_W-1:0]  psum_o,
  output logic                   psum_valid_o
);

  localparam int LATENCY  = latency(ROWS, COLS);
  localparam int ROW_CW   = cnt_w(ROWS);
  localparam int FLIGHT_W = cnt_w(LATENCY);

  state_e              state, state_next;
  logic [ROW_CW-1:0]   row_cnt, cnt_next;
  logic [FLIGHT_W-1:0] inflight;
  logic                w_load, data_acc, v_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_next;
      row_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = row_cnt;
    w_load           = 1'b0;
    weight_ready_o   = 1'b0;
    data_ready_o     = 1'b0;
    weights_loaded_o = 1'b0;
    case (state)
      IDLE: begin
        weight_ready_o = 1'b1;
        if (weights_clear_i) begin
          cnt_next = '0;
        end else if (weight_valid_i) begin
          w_load     = 1'b1;
          cnt_next   = ROW_CW'(1);
          state_next = (ROWS == 1) ? LOADED : LOAD;
        end
      end
      LOAD: begin
        weight_ready_o = 1'b1;
        if (weights_clear_i) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (weight_valid_i) begin
          w_load   = 1'b1;
          cnt_next = row_cnt + 1'b1;
          if (row_cnt + 1'b1 == ROW_CW'(ROWS)) state_next = LOADED;
        end
      end
      LOADED: begin
        data_ready_o     = 1'b1;
        weights_loaded_o = 1'b1;
        if (weights_clear_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_acc = data_valid_i && data_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (data_acc && !psum_valid_o) begin
      inflight <= inflight + 1'b1;
    end else if (!data_acc && psum_valid_o) begin
      inflight <= inflight - 1'b1;
    end
  end

  logic [DATA_W-1:0] x_skew [ROWS];
  logic [ROWS-1:0]   v_skew;
  logic [DATA_W-1:0] w_grid [ROWS][COLS];
  logic [DATA_W-1:0] x_grid [ROWS][COLS];
  logic              v_grid [ROWS][COLS];
  logic [ACC_W-1:0]  p_grid [ROWS][COLS];
  logic [ACC_W-1:0]  dsk    [COLS];

  // Row r is delayed r cycles so it meets the psum wavefront coming down.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign x_skew[r] = data_i[DATA_W-1:0];
      assign v_skew[r] = data_acc;
    end else begin : g_delay
      logic [DATA_W-1:0] sr [r];
      logic [r-1:0]      vr;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
          vr <= '0;
        end else begin
          sr[0] <= data_i[r*DATA_W +: DATA_W];
          vr[0] <= data_acc;
          for (int i = 1; i < r; i++) begin
            sr[i] <= sr[i-1];
            vr[i] <= vr[i-1];
          end
        end
      end
      assign x_skew[r] = sr[r-1];
      assign v_skew[r] = vr[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] x_unused;
    logic              v_unused;
    assign x_unused = x_grid[r][COLS-1];
    assign v_unused = v_grid[r][COLS-1];
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] w_src, x_src;
      logic              v_src;
      logic [ACC_W-1:0]  p_src;
      if (r == 0) begin : g_top
        assign w_src = weight_i[c*DATA_W +: DATA_W];
        assign p_src = '0;
      end else begin : g_mid
        assign w_src = w_grid[r-1][c];
        assign p_src = p_grid[r-1][c];
      end
      if (c == 0) begin : g_left
        assign x_src = x_skew[r];
        assign v_src = v_skew[r];
      end else begin : g_inner
        assign x_src = x_grid[r][c-1];
        assign v_src = v_grid[r][c-1];
      end
      if (r == ROWS - 1) begin : g_wsink
        logic [DATA_W-1:0] w_unused;
        assign w_unused = w_grid[r][c];
      end
      sysray_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk        (clk),
        .rst        (rst),
        .w_load     (w_load),
        .w_in       (w_src),
        .w_out      (w_grid[r][c]),
        .x_in       (x_src),
        .x_valid_in (v_src),
        .x_out      (x_grid[r][c]),
        .x_valid_out(v_grid[r][c]),
        .psum_in    (p_src),
        .psum_out   (p_grid[r][c])
      );
    end
  end

  // Earlier columns finish sooner; pad them so a whole vector leaves together.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign dsk[c] = p_grid[ROWS-1][c];
    end else begin : g_delay
      logic [ACC_W-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= p_grid[ROWS-1][c];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign dsk[c] = sr[D-1];
    end
  end

  assign v_final = v_grid[ROWS-1][COLS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      psum_o       <= '0;
      psum_valid_o <= 1'b0;
    end else begin
      psum_valid_o <= v_final;
      if (v_final) begin
        for (int c = 0; c < COLS; c++) psum_o[c*ACC_W +: ACC_W] <= dsk[c];
      end
    end
  end

endmodule

// File: tb/tb_sysray_n.sv
// Directed bench for sysray_n: 2x2 tile with a 32-bit accumulator plus a 16-bit one for wrap.
module tb_sysray_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] weight_i;
  logic        weight_valid_i, weight_ready_o, weights_clear_i, weights_loaded_o;
  logic [15:0] data_i;
  logic        data_valid_i, data_ready_o;
  logic [63:0] psum_o;
  logic        psum_valid_o;

  logic [15:0] w16_i, d16_i;
  logic        w16_valid, w16_ready, w16_loaded, d16_valid, d16_ready;
  logic [31:0] p16_o;
  logic        p16_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sysray_n #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .weight_i(weight_i), .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o),
    .weights_clear_i(weights_clear_i), .weights_loaded_o(weights_loaded_o),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .psum_o(psum_o), .psum_valid_o(psum_valid_o)
  );

  sysray_n #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .weight_i(w16_i), .weight_valid_i(w16_valid), .weight_ready_o(w16_ready),
    .weights_clear_i(1'b0), .weights_loaded_o(w16_loaded),
    .data_i(d16_i), .data_valid_i(d16_valid), .data_ready_o(d16_ready),
    .psum_o(p16_o), .psum_valid_o(p16_valid)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_row(input logic [15:0] w);
    weight_i = w;
    weight_valid_i = 1'b1;
    tick();
    weight_valid_i = 1'b0;
  endtask

  initial begin
    logic saw_pulse;
    rst = 1'b1;
    weight_i = '0; weight_valid_i = 1'b0; weights_clear_i = 1'b0;
    data_i = '0; data_valid_i = 1'b0;
    w16_i = '0; w16_valid = 1'b0; d16_i = '0; d16_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_psum", psum_o, 64'h0);
    chk("rst_psum_valid", psum_valid_o, 1'b0);
    chk("rst_loaded", weights_loaded_o, 1'b0);
    chk("rst_data_ready", data_ready_o, 1'b0);
    chk("rst_weight_ready", weight_ready_o, 1'b1);
    rst = 1'b0;

    // Rows land bottom-up: W[1]=(3,4), W[0]=(1,2)
    load_row({8'd4, 8'd3});
    chk("load1_loaded", weights_loaded_o, 1'b0);
    chk("load1_ready", weight_ready_o, 1'b1);
    load_row({8'd2, 8'd1});
    chk("load2_loaded", weights_loaded_o, 1'b1);
    chk("load2_data_ready", data_ready_o, 1'b1);
    chk("load2_weight_ready", weight_ready_o, 1'b0);

    // single vector, latency 4
    data_i = {8'd6, 8'd5}; data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("lat_early_valid", psum_valid_o, 1'b0);
      tick();
    end
    chk("lat_valid", psum_valid_o, 1'b1);
    chk("lat_psum", psum_o, {32'd34, 32'd23});
    tick();
    chk("pulse_single", psum_valid_o, 1'b0);
    chk("psum_hold", psum_o, {32'd34, 32'd23});

    // back-to-back stream
    data_i = {8'd6, 8'd5}; data_valid_i = 1'b1; tick();
    data_i = {8'd1, 8'd1}; tick();
    data_i = {8'd0, 8'hFE}; tick();
    data_valid_i = 1'b0;
    tick();
    chk("b2b_v0", psum_valid_o, 1'b1);
    chk("b2b_p0", psum_o, {32'd34, 32'd23});
    tick();
    chk("b2b_v1", psum_valid_o, 1'b1);
    chk("b2b_p1", psum_o, {32'd6, 32'd4});
    tick();
    chk("b2b_v2", psum_valid_o, 1'b1);
    chk("b2b_p2", psum_o, {32'hFFFF_FFFC, 32'hFFFF_FFFE});
    tick();
    chk("b2b_end", psum_valid_o, 1'b0);

    // bubbles, with weight beats offered while LOADED
    weight_i = {8'd9, 8'd9}; weight_valid_i = 1'b1;
    data_i = {8'd2, 8'd1}; data_valid_i = 1'b1; tick();
    data_valid_i = 1'b0; tick();
    data_i = {8'd4, 8'd3}; data_valid_i = 1'b1; tick();
    data_valid_i = 1'b0; tick();
    chk("bub_v0", psum_valid_o, 1'b1);
    chk("bub_p0", psum_o, {32'd10, 32'd7});
    tick();
    chk("bub_gap", psum_valid_o, 1'b0);
    tick();
    chk("bub_v1", psum_valid_o, 1'b1);
    chk("bub_p1", psum_o, {32'd22, 32'd15});
    weight_valid_i = 1'b0;
    tick();

    // clear with a vector accepted in the same cycle
    data_i = {8'd6, 8'd5}; data_valid_i = 1'b1; weights_clear_i = 1'b1;
    tick();
    data_valid_i = 1'b0; weights_clear_i = 1'b0;
    chk("drain_data_ready", data_ready_o, 1'b0);
    chk("drain_loaded", weights_loaded_o, 1'b0);
    chk("drain_weight_ready", weight_ready_o, 1'b0);
    tick();
    tick();
    chk("drain_still", data_ready_o, 1'b0);
    tick();
    chk("drain_v", psum_valid_o, 1'b1);
    chk("drain_p", psum_o, {32'd34, 32'd23});
    tick();
    chk("drain_not_idle", weight_ready_o, 1'b0);
    tick();
    chk("drain_idle", weight_ready_o, 1'b1);

    // identity reload
    load_row({8'd1, 8'd0});
    load_row({8'd0, 8'd1});
    chk("id_loaded", weights_loaded_o, 1'b1);
    data_i = {8'd9, 8'd7}; data_valid_i = 1'b1; tick();
    data_valid_i = 1'b0;
    tick(); tick(); tick();
    chk("id_v", psum_valid_o, 1'b1);
    chk("id_p", psum_o, {32'd9, 32'd7});

    // 16-bit accumulator wrap: 16384 + 16384 -> 0x8000
    w16_i = 16'h8080; w16_valid = 1'b1; tick(); tick();
    w16_valid = 1'b0;
    chk("wrap_loaded", w16_loaded, 1'b1);
    d16_i = 16'h8080; d16_valid = 1'b1; tick();
    d16_valid = 1'b0;
    tick(); tick(); tick();
    chk("wrap_v", p16_valid, 1'b1);
    chk("wrap_p", p16_o, 32'h8000_8000);

    // reset during LOAD
    tick();
    weights_clear_i = 1'b1; tick(); weights_clear_i = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    load_row({8'd4, 8'd3});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rload_weight_ready", weight_ready_o, 1'b1);
    chk("rload_loaded", weights_loaded_o, 1'b0);
    chk("rload_psum", psum_o, 64'h0);
    load_row({8'd4, 8'd3});
    chk("rload_restart", weights_loaded_o, 1'b0);
    load_row({8'd2, 8'd1});
    chk("rload_done", weights_loaded_o, 1'b1);

    // reset with three vectors in flight
    data_i = {8'd6, 8'd5}; data_valid_i = 1'b1; tick();
    data_i = {8'd1, 8'd1}; tick();
    data_i = {8'd2, 8'd2}; tick();
    data_valid_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rfly_valid", psum_valid_o, 1'b0);
    chk("rfly_psum", psum_o, 64'h0);
    chk("rfly_loaded", weights_loaded_o, 1'b0);
    chk("rfly_data_ready", data_ready_o, 1'b0);
    chk("rfly_weight_ready", weight_ready_o, 1'b1);
    saw_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (psum_valid_o) saw_pulse = 1'b1;
    end
    chk("rfly_no_pulse", saw_pulse, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
